// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start + DATA_BITS + optional parity + stop.
// Ports: clk, rst_n (async low), send, data[7:0] in; tx, busy, done out.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // Wide enough for the 2-stop-bit span at the largest baud divisor.
    localparam int CW = 17;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]    MASK      = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      masked;
    logic            bit_end;
    logic            stop_end;

    assign masked   = data & MASK;
    assign bit_end  = (cnt_q == BIT_LAST);
    assign stop_end = (cnt_q == STOP_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (stop_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A request is taken when idle, or on the last stop cycle so a
        // following frame starts with no idle gap.
        if ((state_q == IDLE) || ((state_q == STOP) && stop_end)) begin
            if (send) begin
                state_d = START;
                cnt_d   = '0;
                idx_d   = '0;
                shift_d = masked;
                par_d   = (PARITY == 1) ? ~^masked : ^masked;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
